wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: alu_valid / alu_addr / alu_data  in  1/5/32  ALU writeback request, register address and data.
REQ-004 SHALL have ports: alu_ready  out  1  ALU request accepted this cycle when alu_valid && alu_ready.
REQ-005 SHALL have ports: mem_valid / mem_addr / mem_data  in  1/5/32  MMU load writeback request, register address and data.
REQ-006 SHALL have ports: mem_ready  out  1  MMU request accepted when mem_valid && mem_ready.
REQ-007 SHALL have ports: wb_write / wb_addr / wb_data  out  1/5/32  single register-bank write port (drives write_in / addr_d_in / d_in).
REQ-008 SHALL have ports: src_a / src_b  in  5/5  decode source register addresses.
REQ-009 SHALL have ports: busy_a / busy_b  out  1/1  source register has a write pending in this block.

Function
REQ-010 SHALL hold one 2-entry FIFO per requester (ALU, MEM), each entry {addr, data}.
REQ-011 SHALL drive xxx_ready = FIFO not full; a full FIFO SHALL NOT accept a push even if popped in the same cycle.
REQ-012 SHALL select at most one FIFO head per cycle, pop it, and register it into wb_write/wb_addr/wb_data on the same edge.
REQ-013 SHALL give a minimum latency of 2 edges: push at edge k, wb_write high for exactly one cycle after edge k+1.
REQ-014 SHALL deassert wb_write in any cycle following an edge with no grant; wb_addr/wb_data hold their last value.
REQ-015 SHALL grant by default with fixed priority MEM > ALU.
REQ-016 SHALL keep a 2-bit ALU wait counter: +1 on each edge where the ALU head is non-empty and not granted; when it reaches 3, the next grant goes to ALU; cleared on ALU grant or when the ALU FIFO is empty.
REQ-017 SHALL preserve per-requester order (FIFO); no cross-requester ordering is guaranteed.
REQ-018 SHALL assert busy_a when src_a matches any valid FIFO entry or a wb_write-valid output register; busy_b likewise, combinationally.
REQ-019 SHALL rely on decode stalling on busy_x, so that no two writes to the same register are outstanding; behaviour for same-address conflicts is otherwise unspecified.
REQ-020 SHALL treat simultaneous push and pop on a 1-entry FIFO as legal; occupancy stays 1.
REQ-021 SHALL use wrap-around read/write pointers modulo 2 plus a count of 0..2.

Reset
REQ-022 SHALL, on reset, empty both FIFOs, clear the wait counter and round-robin pointer, and drive wb_write=0, wb_addr=0, wb_data=0.
REQ-023 SHALL drive alu_ready=1 and mem_ready=1 in the first cycle after reset; requests presented during reset SHALL be dropped.
REQ-024 SHALL discard in-flight entries on reset mid-operation, with no wb_write in the cycle after the reset edge.

Configuration
REQ-025 SHALL, with WB_RR_ARB_EN defined, replace REQ-015/016 with round-robin: the 1-bit last-grant pointer favours the requester not granted last when both are non-empty; the wait counter is omitted.
REQ-026 SHALL, without WB_RR_ARB_EN, implement fixed priority with the anti-starvation counter.

Structure
REQ-027 SHALL place the register address width (5), data width (32) and FIFO depth (2) constants in the shared core package.
REQ-028 SHALL implement the FIFO as one sub-module, wb_fifo, instantiated twice.

Verification
REQ-029 Single ALU push {addr=3, data=0x11} into empty block -> wb_write=1, wb_addr=3, wb_data=0x11 one cycle after the following edge; busy_a=1 with src_a=3 until then.
REQ-030 ALU {5,0xA} and MEM {6,0xB} pushed on the same edge -> MEM written first, ALU on the next cycle.
REQ-031 MEM valid every cycle, ALU with one entry -> ALU granted no later than the 4th grant cycle (fixed priority); with WB_RR_ARB_EN, grants alternate.
REQ-032 Three back-to-back ALU pushes with no pops -> alu_ready=0 after 2 accepted, third held until a pop; all three written in order.
REQ-033 Reset asserted with both FIFOs full -> next cycle wb_write=0, both ready=1, busy_a=busy_b=0.
REQ-034 Push and pop on a 1-entry ALU FIFO in the same cycle -> occupancy 1, alu_ready stays 1, output data in push order.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, FIFO geometry and entry/grant types for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = 1;
    localparam int CNT_W      = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } grant_e;

    // Pointers wrap naturally because the depth is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: 2-entry writeback request queue with per-entry source-address match
// outputs used for the decode hazard (busy) check.
module wb_fifo
    import wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  wb_entry_t           i_entry,
    input  logic                i_pop,
    input  logic [ADDR_W-1:0]   i_src_a,
    input  logic [ADDR_W-1:0]   i_src_b,
    output logic                o_ready,
    output logic                o_empty,
    output wb_entry_t           o_head,
    output logic                o_match_a,
    output logic                o_match_b
);

    wb_entry_t          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_push;
    logic [FIFO_DEPTH-1:0] w_hit_a;
    logic [FIFO_DEPTH-1:0] w_hit_b;

    // Readiness looks only at the registered count, so a full FIFO refuses a
    // push even when its head is popped on the same edge.
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push   = i_valid && !w_full;
    assign o_ready  = !w_full;
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_entry;
    end

    // An entry is live when its distance from the read pointer is below the count.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] w_offset;
            logic             w_live;
            assign w_offset    = PTR_W'(gi) - r_rd_ptr;
            assign w_live      = (CNT_W'(w_offset) < r_count);
            assign w_hit_a[gi] = w_live && (r_mem[gi].addr == i_src_a);
            assign w_hit_b[gi] = w_live && (r_mem[gi].addr == i_src_b);
        end
    endgenerate

    assign o_match_a = |w_hit_a;
    assign o_match_b = |w_hit_b;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter merging ALU and MMU results onto one register-file write port.
// Define WB_RR_ARB_EN for round-robin; default is MEM-first with an ALU wait counter.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    output logic                wb_write,
    output logic [ADDR_W-1:0]   wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    input  logic [ADDR_W-1:0]   src_a,
    input  logic [ADDR_W-1:0]   src_b,
    output logic                busy_a,
    output logic                busy_b
);

    wb_entry_t  w_alu_entry, w_mem_entry, w_alu_head, w_mem_head;
    logic       w_alu_empty, w_mem_empty;
    logic       w_alu_match_a, w_alu_match_b, w_mem_match_a, w_mem_match_b;
    grant_e     w_grant;

    logic                r_wb_write;
    logic [ADDR_W-1:0]   r_wb_addr;
    logic [DATA_W-1:0]   r_wb_data;

    assign w_alu_entry = {alu_addr, alu_data};
    assign w_mem_entry = {mem_addr, mem_data};

    wb_fifo u_alu_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (alu_valid),
        .i_entry   (w_alu_entry),
        .i_pop     (w_grant == GNT_ALU),
        .i_src_a   (src_a),
        .i_src_b   (src_b),
        .o_ready   (alu_ready),
        .o_empty   (w_alu_empty),
        .o_head    (w_alu_head),
        .o_match_a (w_alu_match_a),
        .o_match_b (w_alu_match_b)
    );

    wb_fifo u_mem_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (mem_valid),
        .i_entry   (w_mem_entry),
        .i_pop     (w_grant == GNT_MEM),
        .i_src_a   (src_a),
        .i_src_b   (src_b),
        .o_ready   (mem_ready),
        .o_empty   (w_mem_empty),
        .o_head    (w_mem_head),
        .o_match_a (w_mem_match_a),
        .o_match_b (w_mem_match_b)
    );

`ifdef WB_RR_ARB_EN
    logic r_last_mem;   // 1 when the most recent grant went to MEM

    always_comb begin
        w_grant = GNT_NONE;
        if (!w_alu_empty && !w_mem_empty)
            w_grant = r_last_mem ? GNT_ALU : GNT_MEM;
        else if (!w_mem_empty)
            w_grant = GNT_MEM;
        else if (!w_alu_empty)
            w_grant = GNT_ALU;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_last_mem <= 1'b0;
        else if (w_grant != GNT_NONE)
            r_last_mem <= (w_grant == GNT_MEM);
    end
`else
    logic [1:0] r_wait;

    // A saturated wait count overrides MEM priority for one grant.
    always_comb begin
        w_grant = GNT_NONE;
        if (!w_alu_empty && (w_mem_empty || r_wait == 2'd3))
            w_grant = GNT_ALU;
        else if (!w_mem_empty)
            w_grant = GNT_MEM;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_wait <= 2'd0;
        else if (w_alu_empty || w_grant == GNT_ALU)
            r_wait <= 2'd0;
        else if (r_wait != 2'd3)
            r_wait <= r_wait + 2'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_write <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_write <= (w_grant != GNT_NONE);
            if (w_grant == GNT_ALU) begin
                r_wb_addr <= w_alu_head.addr;
                r_wb_data <= w_alu_head.data;
            end else if (w_grant == GNT_MEM) begin
                r_wb_addr <= w_mem_head.addr;
                r_wb_data <= w_mem_head.data;
            end
        end
    end

    assign wb_write = r_wb_write;
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;

    assign busy_a = w_alu_match_a || w_mem_match_a || (r_wb_write && (r_wb_addr == src_a));
    assign busy_b = w_alu_match_b || w_mem_match_b || (r_wb_write && (r_wb_addr == src_b));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter; expected values assume the default
// fixed-priority build (WB_RR_ARB_EN undefined).
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  src_a, src_b;
    logic        busy_a, busy_b;

    wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .wb_write  (wb_write),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs held for one cycle and outputs expected in that cycle,
    // before the rising edge that ends it.
    typedef struct {
        logic        chk;
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        ar;
        logic        mr;
        logic        ww;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ba;
        logic        bb;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(
        input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic [4:0] sa, input logic [4:0] sb,
        input logic ar, input logic mr, input logic ww, input logic [4:0] wa,
        input logic [31:0] wd, input logic ba, input logic bb);
        vec_t v;
        v.chk = 1'b1; v.rst = rst;
        v.av = av; v.aa = aa; v.ad = ad;
        v.mv = mv; v.ma = ma; v.md = md;
        v.sa = sa; v.sb = sb;
        v.ar = ar; v.mr = mr; v.ww = ww; v.wa = wa; v.wd = wd;
        v.ba = ba; v.bb = bb;
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    task automatic add_rst();
        vec_t v;
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.chk = 1'b0;
        tbl.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", n_vec, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset     = v.rst;
        alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
        mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
        src_a     = v.sa; src_b    = v.sb;
        #1;
        if (v.chk) begin
            n_vec++;
            cmp("alu_ready", 32'(alu_ready), 32'(v.ar));
            cmp("mem_ready", 32'(mem_ready), 32'(v.mr));
            cmp("wb_write",  32'(wb_write),  32'(v.ww));
            cmp("wb_addr",   32'(wb_addr),   32'(v.wa));
            cmp("wb_data",   wb_data,        v.wd);
            cmp("busy_a",    32'(busy_a),    32'(v.ba));
            cmp("busy_b",    32'(busy_b),    32'(v.bb));
            $display("vec %3d rst=%0d alu=%0d/%0d/%08h mem=%0d/%0d/%08h -> wb=%0d/%0d/%08h rdy=%0d%0d busy=%0d%0d",
                     n_vec, v.rst, v.av, v.aa, v.ad, v.mv, v.ma, v.md,
                     wb_write, wb_addr, wb_data, alu_ready, mem_ready, busy_a, busy_b);
        end
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        src_a = '0; src_b = '0;

        //   rst av aa  ad     mv ma  md     sa  sb   ar mr ww wa  wd     ba bb
        add_rst();
        add_rst();
        // Reset state, then single ALU write to r3
        add(mk(0, 0, 0,  0,     0, 0,  0,     0,  0,   1, 1, 0, 0,  0,     0, 0));
        add(mk(0, 1, 3,  'h11,  0, 0,  0,     3,  0,   1, 1, 0, 0,  0,     0, 0));
        add(mk(0, 0, 0,  0,     0, 0,  0,     3,  0,   1, 1, 0, 0,  0,     1, 0));
        add(mk(0, 0, 0,  0,     0, 0,  0,     3,  0,   1, 1, 1, 3,  'h11,  1, 0));
        add(mk(0, 0, 0,  0,     0, 0,  0,     3,  0,   1, 1, 0, 3,  'h11,  0, 0));
        // Simultaneous ALU/MEM push: MEM written first
        add(mk(0, 1, 5,  'hA,   1, 6,  'hB,   5,  6,   1, 1, 0, 3,  'h11,  0, 0));
        add(mk(0, 0, 0,  0,     0, 0,  0,     5,  6,   1, 1, 0, 3,  'h11,  1, 1));
        add(mk(0, 0, 0,  0,     0, 0,  0,     5,  6,   1, 1, 1, 6,  'hB,   1, 1));
        add(mk(0, 0, 0,  0,     0, 0,  0,     5,  6,   1, 1, 1, 5,  'hA,   1, 0));
        add(mk(0, 0, 0,  0,     0, 0,  0,     5,  6,   1, 1, 0, 5,  'hA,   0, 0));
        // MEM streaming, three ALU pushes: ALU full, wins on the 4th grant, in order
        add(mk(0, 1, 7,  'h71,  1, 16, 'h80,  9,  20,  1, 1, 0, 5,  'hA,   0, 0));
        add(mk(0, 1, 8,  'h72,  1, 17, 'h81,  9,  20,  1, 1, 0, 5,  'hA,   0, 0));
        add(mk(0, 1, 9,  'h73,  1, 18, 'h82,  9,  20,  0, 1, 1, 16, 'h80,  0, 0));
        add(mk(0, 1, 9,  'h73,  1, 19, 'h83,  9,  20,  0, 1, 1, 17, 'h81,  0, 0));
        add(mk(0, 1, 9,  'h73,  1, 20, 'h84,  9,  20,  0, 1, 1, 18, 'h82,  0, 0));
        add(mk(0, 1, 9,  'h73,  0, 0,  0,     9,  20,  1, 0, 1, 7,  'h71,  0, 1));
        add(mk(0, 0, 0,  0,     0, 0,  0,     9,  20,  0, 1, 1, 19, 'h83,  1, 1));
        add(mk(0, 0, 0,  0,     0, 0,  0,     9,  20,  0, 1, 1, 20, 'h84,  1, 1));
        add(mk(0, 0, 0,  0,     0, 0,  0,     9,  20,  1, 1, 1, 8,  'h72,  1, 0));
        add(mk(0, 0, 0,  0,     0, 0,  0,     9,  20,  1, 1, 1, 9,  'h73,  1, 0));
        add(mk(0, 0, 0,  0,     0, 0,  0,     9,  20,  1, 1, 0, 9,  'h73,  0, 0));
        // Push + pop on a 1-entry ALU FIFO: stays ready, push order preserved
        add(mk(0, 1, 10, 'h90,  0, 0,  0,     11, 10,  1, 1, 0, 9,  'h73,  0, 0));
        add(mk(0, 1, 11, 'h91,  0, 0,  0,     11, 10,  1, 1, 0, 9,  'h73,  0, 1));
        add(mk(0, 0, 0,  0,     0, 0,  0,     11, 10,  1, 1, 1, 10, 'h90,  1, 1));
        add(mk(0, 0, 0,  0,     0, 0,  0,     11, 10,  1, 1, 1, 11, 'h91,  1, 0));
        add(mk(0, 0, 0,  0,     0, 0,  0,     11, 10,  1, 1, 0, 11, 'h91,  0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Mid-operation reset: ALU full, MEM holding one entry, a write in flight,
        // and fresh requests presented during the reset cycle.
        apply(mk(0, 1, 1, 'h100, 1, 2, 'h200, 1, 4,   1, 1, 0, 11, 'h91,  0, 0));
        apply(mk(0, 1, 3, 'h300, 1, 4, 'h400, 1, 4,   1, 1, 0, 11, 'h91,  1, 0));
        apply(mk(1, 1, 5, 'h500, 1, 6, 'h600, 1, 4,   0, 1, 1, 2,  'h200, 1, 1));
        apply(mk(0, 0, 0, 0,     0, 0, 0,     1, 4,   1, 1, 0, 0,  0,     0, 0));
        apply(mk(0, 0, 0, 0,     0, 0, 0,     5, 6,   1, 1, 0, 0,  0,     0, 0));
        apply(mk(0, 0, 0, 0,     0, 0, 0,     3, 2,   1, 1, 0, 0,  0,     0, 0));
        apply(mk(0, 0, 0, 0,     0, 0, 0,     5, 6,   1, 1, 0, 0,  0,     0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
